esm_config_decoder: RTL and testbench

Parses ESM control messages arriving on the configuration AXI-stream and dispatches them to the internal modules, such as the dwell controller.
- Message format: word0 = magic number; word1 = sequence number; word2 = {module_id[31:24], message_type[23:16], 16'h0000}; word3 = padding; words 4+ = payload.
- Validates the magic number and the sequence number.
- Strips the header and presents payload words with a word index and first/last markers on a broadcast config bus.
- Single clock domain; sits after the AXI clock-domain crossing.

---
 rtl/esm_config_decoder_if.sv | 23 ++
 rtl/esm_config_decoder.sv | 153 +++++++++++++++
 tb/tb_esm_config_decoder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/esm_config_decoder_if.sv
// Configuration AXI-stream carrying ESM control messages into the decoder.
interface esm_config_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  S_axis_valid;
    logic                  S_axis_ready;
    logic [DATA_WIDTH-1:0] S_axis_data;
    logic                  S_axis_last;

    modport master (
        output S_axis_valid,
        output S_axis_data,
        output S_axis_last,
        input  S_axis_ready
    );

    modport slave (
        input  S_axis_valid,
        input  S_axis_data,
        input  S_axis_last,
        output S_axis_ready
    );
endinterface

// File: rtl/esm_config_decoder.sv
// Parses ESM control messages (magic, sequence, id/type, pad, payload) and
// broadcasts the payload words with index and first/last markers.
module esm_config_decoder #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [31:0] MAGIC_NUM      = 32'hE5C0_F16A,
    parameter int          INDEX_WIDTH    = 8
) (
    input  logic                      Clk,
    input  logic                      Rst,
    esm_config_decoder_if.slave       s_axis,
    output logic                      Module_config_valid,
    output logic                      Module_config_first,
    output logic                      Module_config_last,
    output logic [7:0]                Module_config_module_id,
    output logic [7:0]                Module_config_message_type,
    output logic [INDEX_WIDTH-1:0]    Module_config_index,
    output logic [AXI_DATA_WIDTH-1:0] Module_config_data,
    output logic                      Status_magic_error,
    output logic                      Status_seq_error,
    output logic                      Status_short_error,
    output logic [31:0]               Status_msg_count
);

    typedef enum logic [2:0] {
        S_MAGIC,
        S_SEQ,
        S_TYPE,
        S_PAD,
        S_DATA,
        S_DRAIN
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] INDEX_MAX = '1;

    state_t                   state_q, state_d;
    logic                     ready_q;
    logic [31:0]              expected_seq_q;
    logic                     seq_valid_q;
    logic [INDEX_WIDTH-1:0]   word_index_q;

    logic xfer;
    logic magic_err_d, seq_err_d, short_err_d;
    logic beat_d, count_inc_d, seq_load_d, type_load_d, data_start_d;

    assign s_axis.S_axis_ready = ready_q;
    assign xfer = s_axis.S_axis_valid && ready_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        magic_err_d  = 1'b0;
        seq_err_d    = 1'b0;
        short_err_d  = 1'b0;
        beat_d       = 1'b0;
        count_inc_d  = 1'b0;
        seq_load_d   = 1'b0;
        type_load_d  = 1'b0;
        data_start_d = 1'b0;
        if (xfer) begin
            unique case (state_q)
                S_MAGIC: begin
                    if (s_axis.S_axis_data == MAGIC_NUM) begin
                        short_err_d = s_axis.S_axis_last;
                        state_d     = s_axis.S_axis_last ? S_MAGIC : S_SEQ;
                    end else begin
                        magic_err_d = 1'b1;
                        state_d     = s_axis.S_axis_last ? S_MAGIC : S_DRAIN;
                    end
                end
                S_SEQ: begin
                    // A sequence number is tracked even if the message turns out short.
                    seq_load_d  = 1'b1;
                    seq_err_d   = seq_valid_q && (s_axis.S_axis_data != expected_seq_q);
                    short_err_d = s_axis.S_axis_last;
                    state_d     = s_axis.S_axis_last ? S_MAGIC : S_TYPE;
                end
                S_TYPE: begin
                    type_load_d = !s_axis.S_axis_last;
                    short_err_d = s_axis.S_axis_last;
                    state_d     = s_axis.S_axis_last ? S_MAGIC : S_PAD;
                end
                S_PAD: begin
                    data_start_d = !s_axis.S_axis_last;
                    short_err_d  = s_axis.S_axis_last;
                    state_d      = s_axis.S_axis_last ? S_MAGIC : S_DATA;
                end
                S_DATA: begin
                    beat_d      = 1'b1;
                    count_inc_d = s_axis.S_axis_last;
                    state_d     = s_axis.S_axis_last ? S_MAGIC : S_DATA;
                end
                S_DRAIN: begin
                    state_d = s_axis.S_axis_last ? S_MAGIC : S_DRAIN;
                end
                default: state_d = S_MAGIC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q                    <= S_MAGIC;
            ready_q                    <= 1'b0;
            expected_seq_q             <= '0;
            seq_valid_q                <= 1'b0;
            word_index_q               <= '0;
            Module_config_valid        <= 1'b0;
            Module_config_first        <= 1'b0;
            Module_config_last         <= 1'b0;
            Module_config_module_id    <= '0;
            Module_config_message_type <= '0;
            Module_config_index        <= '0;
            Module_config_data         <= '0;
            Status_magic_error         <= 1'b0;
            Status_seq_error           <= 1'b0;
            Status_short_error         <= 1'b0;
            Status_msg_count           <= '0;
        end else begin
            state_q             <= state_d;
            ready_q             <= 1'b1;
            Status_magic_error  <= magic_err_d;
            Status_seq_error    <= seq_err_d;
            Status_short_error  <= short_err_d;
            Module_config_valid <= beat_d;
            Module_config_first <= beat_d && (word_index_q == '0);
            Module_config_last  <= beat_d && s_axis.S_axis_last;

            if (seq_load_d) begin
                expected_seq_q <= s_axis.S_axis_data + 32'd1;
                seq_valid_q    <= 1'b1;
            end
            if (type_load_d) begin
                Module_config_module_id    <= s_axis.S_axis_data[31:24];
                Module_config_message_type <= s_axis.S_axis_data[23:16];
            end
            if (data_start_d) begin
                word_index_q <= '0;
            end
            if (beat_d) begin
                Module_config_data  <= s_axis.S_axis_data;
                Module_config_index <= word_index_q;
                if (word_index_q != INDEX_MAX) begin
                    word_index_q <= word_index_q + 1'b1;
                end
            end
            if (count_inc_d) begin
                Status_msg_count <= Status_msg_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_esm_config_decoder.sv
// Scoreboard bench for esm_config_decoder: directed messages, monitor-side beat checking.
module tb_esm_config_decoder;

    localparam logic [31:0] MAGIC = 32'hE5C0_F16A;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  typ;
        logic [7:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        Clk;
    logic        Rst;
    logic        cfg_valid, cfg_first, cfg_last;
    logic [7:0]  cfg_id, cfg_type, cfg_index;
    logic [31:0] cfg_data;
    logic        magic_err, seq_err, short_err;
    logic [31:0] msg_count;

    int checks   = 0;
    int failures = 0;
    int n_magic  = 0;
    int n_seq    = 0;
    int n_short  = 0;
    int b_magic, b_seq, b_short;
    int exp_count = 0;
    beat_t sb_q[$];

    esm_config_decoder_if #(.DATA_WIDTH(32)) axis ();

    esm_config_decoder #(
        .AXI_DATA_WIDTH(32),
        .MAGIC_NUM     (MAGIC),
        .INDEX_WIDTH   (8)
    ) dut (
        .Clk                       (Clk),
        .Rst                       (Rst),
        .s_axis                    (axis.slave),
        .Module_config_valid       (cfg_valid),
        .Module_config_first       (cfg_first),
        .Module_config_last        (cfg_last),
        .Module_config_module_id   (cfg_id),
        .Module_config_message_type(cfg_type),
        .Module_config_index       (cfg_index),
        .Module_config_data        (cfg_data),
        .Status_magic_error        (magic_err),
        .Status_seq_error          (seq_err),
        .Status_short_error        (short_err),
        .Status_msg_count          (msg_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per observed output beat; counts error pulse cycles.
    always @(negedge Clk) begin
        if (cfg_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {63'd0, cfg_valid}, 64'd0);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("beat", {6'd0, cfg_first, cfg_last, cfg_id, cfg_type, cfg_index, cfg_data},
                      {6'd0, e});
            end
        end
        if (magic_err === 1'b1) n_magic++;
        if (seq_err === 1'b1)   n_seq++;
        if (short_err === 1'b1) n_short++;
    end

    task automatic send_word(input logic [31:0] data, input logic last);
        int guard;
        guard = 0;
        @(negedge Clk);
        axis.S_axis_valid = 1'b1;
        axis.S_axis_data  = data;
        axis.S_axis_last  = last;
        while (axis.S_axis_ready !== 1'b1) begin
            @(negedge Clk);
            guard++;
            if (guard > 20) begin
                $display("FAIL ready_timeout: got %0b expected 1", axis.S_axis_ready);
                $fatal(1, "ready never asserted");
            end
        end
        @(posedge Clk);
    endtask

    task automatic idle();
        @(negedge Clk);
        axis.S_axis_valid = 1'b0;
        axis.S_axis_last  = 1'b0;
    endtask

    // Full message with n payload words base, base+step, ...; n==0 puts last on the pad word.
    task automatic send_msg(input logic [31:0] seq, input logic [7:0] id, input logic [7:0] typ,
                            input int n, input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.first = (i == 0);
            e.last  = (i == n - 1);
            e.id    = id;
            e.typ   = typ;
            e.idx   = (i > 255) ? 8'd255 : i[7:0];
            e.data  = base + step * i;
            sb_q.push_back(e);
        end
        send_word(MAGIC, 1'b0);
        send_word(seq, 1'b0);
        send_word({id, typ, 16'h0000}, 1'b0);
        send_word(32'hDEADBEEF, n == 0);
        for (int i = 0; i < n; i++) begin
            send_word(base + step * i, i == n - 1);
        end
    endtask

    task automatic snap();
        b_magic = n_magic;
        b_seq   = n_seq;
        b_short = n_short;
    endtask

    task automatic settle_and_check(input string tag, input int dm, input int ds, input int dsh);
        idle();
        repeat (3) @(negedge Clk);
        check({tag, "_magic_err"}, 64'(n_magic - b_magic), 64'(dm));
        check({tag, "_seq_err"},   64'(n_seq - b_seq),     64'(ds));
        check({tag, "_short_err"}, 64'(n_short - b_short), 64'(dsh));
        check({tag, "_msg_count"}, {32'd0, msg_count},     64'(exp_count));
        check({tag, "_beats_left"}, 64'(sb_q.size()),      64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1;
        axis.S_axis_valid = 1'b0;
        axis.S_axis_data  = '0;
        axis.S_axis_last  = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ready",     {63'd0, axis.S_axis_ready}, 64'd0);
        check("rst_valid",     {63'd0, cfg_valid}, 64'd0);
        check("rst_outputs",   {22'd0, cfg_first, cfg_last, cfg_id, cfg_type, cfg_index, cfg_data}, 64'd0);
        check("rst_errors",    {61'd0, magic_err, seq_err, short_err}, 64'd0);
        check("rst_msg_count", {32'd0, msg_count}, 64'd0);
        Rst = 1'b0;
        check("ready_first_cycle", {63'd0, axis.S_axis_ready}, 64'd0);
        @(negedge Clk);
        check("ready_after_rst", {63'd0, axis.S_axis_ready}, 64'd1);

        // Basic 3-word payload.
        snap();
        send_msg(32'd0, 8'h01, 8'h02, 3, 32'h11, 32'h11);
        exp_count = 1;
        settle_and_check("basic", 0, 0, 0);

        // Sequence gap 0 -> 5, then 6 back-to-back with no idle.
        snap();
        send_msg(32'd5, 8'h03, 8'h04, 2, 32'hA0, 32'h1);
        send_msg(32'd6, 8'h05, 8'h06, 1, 32'hB0, 32'h1);
        exp_count = 3;
        settle_and_check("seq_gap", 0, 1, 0);

        // Bad magic, drained until last; next message decodes.
        snap();
        send_word(32'h12345678, 1'b0);
        for (int i = 0; i < 4; i++) send_word(32'h100 + i, i == 3);
        settle_and_check("bad_magic", 1, 0, 0);
        snap();
        send_msg(32'd7, 8'h07, 8'h08, 2, 32'hC0, 32'h4);
        exp_count = 4;
        settle_and_check("after_magic", 0, 0, 0);

        // Reset after 2 payload beats of a message that never ends.
        snap();
        for (int i = 0; i < 2; i++) begin
            beat_t e;
            e.first = (i == 0);
            e.last  = 1'b0;
            e.id    = 8'h09;
            e.typ   = 8'h0A;
            e.idx   = i[7:0];
            e.data  = 32'hD0 + i;
            sb_q.push_back(e);
        end
        send_word(MAGIC, 1'b0);
        send_word(32'd8, 1'b0);
        send_word({8'h09, 8'h0A, 16'h0}, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'hD0, 1'b0);
        send_word(32'hD1, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        axis.S_axis_valid = 1'b0;
        axis.S_axis_last  = 1'b0;
        repeat (2) @(negedge Clk);
        check("midrst_valid", {63'd0, cfg_valid}, 64'd0);
        check("midrst_count", {32'd0, msg_count}, 64'd0);
        Rst = 1'b0;
        exp_count = 0;
        send_msg(32'd0, 8'h0B, 8'h0C, 2, 32'hE0, 32'h1);
        exp_count = 1;
        settle_and_check("after_rst", 0, 0, 0);

        // Short: last on the type word; seq 1 still tracked so seq 2 is clean.
        snap();
        send_word(MAGIC, 1'b0);
        send_word(32'd1, 1'b0);
        send_word({8'h0D, 8'h0E, 16'h0}, 1'b1);
        settle_and_check("short_type", 0, 0, 1);
        snap();
        send_msg(32'd2, 8'h0F, 8'h10, 1, 32'hF0, 32'h1);
        exp_count = 2;
        settle_and_check("after_short", 0, 0, 0);

        // Zero payload words: last on pad is short.
        snap();
        send_msg(32'd3, 8'h11, 8'h12, 0, 32'h0, 32'h0);
        settle_and_check("zero_payload", 0, 0, 1);

        // 300-word payload: index saturates at 255.
        snap();
        send_msg(32'd4, 8'h13, 8'h14, 300, 32'h1000, 32'h3);
        exp_count = 3;
        settle_and_check("long", 0, 0, 0);

        // Bad magic carrying last, next message immediately after.
        snap();
        send_word(32'h0BAD0BAD, 1'b1);
        send_msg(32'd5, 8'h15, 8'h16, 2, 32'h2000, 32'h1);
        exp_count = 4;
        settle_and_check("magic_last", 1, 0, 0);

        // Magic carrying last is short.
        snap();
        send_word(MAGIC, 1'b1);
        settle_and_check("magic_only", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
